// File: rtl/always_for_pkg.sv
// Shared constants and loop-based bit helpers for always_for_bit_ops.
// Helpers work on a 64-bit container and take the live width as an argument.
package always_for_pkg;

    localparam int unsigned DEF_DW = 8;
    localparam int unsigned MAX_DW = 64;
    localparam int unsigned MAX_IW = 6;
    localparam int unsigned MAX_CW = 7;

    typedef logic [MAX_DW-1:0] word_t;
    typedef logic [MAX_IW-1:0] idx_t;
    typedef logic [MAX_CW-1:0] cnt_t;

    function automatic word_t f_rev(word_t x, int unsigned dw);
        word_t r;
        r = '0;
        for (int unsigned i = 0; i < MAX_DW; i++) begin
            if (i < dw) r[MAX_IW'(i)] = x[MAX_IW'(dw - 1 - i)];
        end
        return r;
    endfunction

    function automatic cnt_t f_popcnt(word_t x, int unsigned dw);
        cnt_t c;
        c = '0;
        for (int unsigned i = 0; i < MAX_DW; i++) begin
            if (i < dw) c = c + cnt_t'(x[MAX_IW'(i)]);
        end
        return c;
    endfunction

    // Scan downwards so the last hit is the lowest set bit.
    function automatic idx_t f_lsb_idx(word_t x, int unsigned dw);
        idx_t r;
        r = '0;
        for (int i = MAX_DW - 1; i >= 0; i--) begin
            if (i < int'(dw) && x[MAX_IW'(i)]) r = idx_t'(i);
        end
        return r;
    endfunction

    // Scan upwards so the last hit is the highest set bit.
    function automatic idx_t f_msb_idx(word_t x, int unsigned dw);
        idx_t r;
        r = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i < int'(dw) && x[MAX_IW'(i)]) r = idx_t'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/always_for_bit_ops_if.sv
// Data bundle between the upstream word source and always_for_bit_ops.
interface always_for_bit_ops_if #(
    parameter int unsigned DW = always_for_pkg::DEF_DW
);
    localparam int unsigned IW = $clog2(DW);
    localparam int unsigned CW = $clog2(DW + 1);

    logic [DW-1:0] indata_a;
    logic [DW-1:0] outdata_b;
    logic [CW-1:0] pop_cnt;
    logic          parity;
    logic [IW-1:0] lsb_idx;
    logic [IW-1:0] msb_idx;
    logic          zero;

    modport master (
        output indata_a,
        input  outdata_b, pop_cnt, parity, lsb_idx, msb_idx, zero
    );

    modport slave (
        input  indata_a,
        output outdata_b, pop_cnt, parity, lsb_idx, msb_idx, zero
    );
endinterface

// File: rtl/always_for_stage.sv
// Output register bank, asynchronous active-high reset to zero.
module always_for_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) q_q <= '0;
        else       q_q <= d_i;
    end

    assign q_o = q_q;
endmodule

// File: rtl/always_for_bit_ops.sv
// Registered bit reverse, popcount, parity, lowest/highest set index and zero flag.
// Define ALWAYS_FOR_PIPE_EN to add a second output register stage (2-cycle latency).
module always_for_bit_ops #(
    parameter int unsigned DW = always_for_pkg::DEF_DW,
    parameter int unsigned IW = $clog2(DW),
    parameter int unsigned CW = $clog2(DW + 1)
) (
    input logic            sys_clk,
    input logic            sys_rst,
    always_for_bit_ops_if.slave bus
);
    import always_for_pkg::*;

    localparam int unsigned RW = DW + CW + 1 + IW + IW + 1;

    word_t         a_ext;
    logic [DW-1:0] rev_d;
    logic [CW-1:0] pop_d;
    logic          par_d;
    logic [IW-1:0] lsb_d;
    logic [IW-1:0] msb_d;
    logic          zero_d;
    logic [RW-1:0] res_d;
    logic [RW-1:0] res_q;

    assign a_ext = word_t'(bus.indata_a);

    always_comb begin
        rev_d = '0;
        rev_d = DW'(f_rev(a_ext, DW));
    end

    always_comb begin
        pop_d = '0;
        pop_d = CW'(f_popcnt(a_ext, DW));
    end

    always_comb begin
        par_d = 1'b0;
        for (int i = 0; i < DW; i++) par_d = par_d ^ bus.indata_a[i];
    end

    always_comb begin
        lsb_d = '0;
        lsb_d = IW'(f_lsb_idx(a_ext, DW));
    end

    always_comb begin
        msb_d = '0;
        msb_d = IW'(f_msb_idx(a_ext, DW));
    end

    always_comb begin
        zero_d = 1'b1;
        for (int i = 0; i < DW; i++) begin
            if (bus.indata_a[i]) zero_d = 1'b0;
        end
    end

    assign res_d = {rev_d, pop_d, par_d, lsb_d, msb_d, zero_d};

`ifdef ALWAYS_FOR_PIPE_EN
    logic [RW-1:0] mid_q;

    always_for_stage #(.W(RW)) u_stage0 (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .d_i   (res_d),
        .q_o   (mid_q)
    );

    always_for_stage #(.W(RW)) u_stage1 (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .d_i   (mid_q),
        .q_o   (res_q)
    );
`else
    always_for_stage #(.W(RW)) u_stage0 (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .d_i   (res_d),
        .q_o   (res_q)
    );
`endif

    assign {bus.outdata_b, bus.pop_cnt, bus.parity, bus.lsb_idx, bus.msb_idx, bus.zero} = res_q;
endmodule

// File: tb/tb_always_for_bit_ops.sv
// Table-driven scoreboard bench for always_for_bit_ops at DW=8.
module tb_always_for_bit_ops;
    localparam int unsigned DW = 8;
`ifdef ALWAYS_FOR_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [7:0] rev;
        logic [3:0] pop;
        logic       par;
        logic [2:0] lsb;
        logic [2:0] msb;
        logic       zero;
    } res_t;

    typedef struct packed {
        logic [7:0] a;
        res_t       exp;
    } vec_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    always_for_bit_ops_if #(.DW(DW)) bus ();

    always_for_bit_ops #(.DW(DW)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    res_t  act;
    assign act = {bus.outdata_b, bus.pop_cnt, bus.parity, bus.lsb_idx, bus.msb_idx, bus.zero};

    res_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    vec_t  tbl[16];

    function automatic vec_t mk(logic [7:0] a, logic [7:0] rev, logic [3:0] pop, logic par,
                                logic [2:0] lsb, logic [2:0] msb, logic z);
        vec_t v;
        v.a        = a;
        v.exp.rev  = rev;
        v.exp.pop  = pop;
        v.exp.par  = par;
        v.exp.lsb  = lsb;
        v.exp.msb  = msb;
        v.exp.zero = z;
        return v;
    endfunction

    task automatic check(input string name, input res_t e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got rev=%h pop=%0d par=%b lsb=%0d msb=%0d zero=%b, want rev=%h pop=%0d par=%b lsb=%0d msb=%0d zero=%b",
                     name, act.rev, act.pop, act.par, act.lsb, act.msb, act.zero,
                     e.rev, e.pop, e.par, e.lsb, e.msb, e.zero);
        end
    endtask

    // Drive one word, queue its expectation, compare whatever has emerged.
    task automatic step(input string name, input vec_t v);
        @(negedge sys_clk);
        bus.indata_a = v.a;
        exp_q.push_back(v.exp);
        name_q.push_back(name);
        @(posedge sys_clk);
        #1;
        if (exp_q.size() >= LAT) check(name_q.pop_front(), exp_q.pop_front());
    endtask

    task automatic flush();
        while (exp_q.size() > 0) begin
            @(posedge sys_clk);
            #1;
            check(name_q.pop_front(), exp_q.pop_front());
        end
    endtask

    initial begin
        logic [7:0] one;
        one = 8'h01;

        tbl[0] = mk(8'hFF, 8'hFF, 4'd8, 1'b0, 3'd0, 3'd7, 1'b0);
        tbl[1] = mk(8'h96, 8'h69, 4'd4, 1'b0, 3'd1, 3'd7, 1'b0);
        tbl[2] = mk(8'h00, 8'h00, 4'd0, 1'b0, 3'd0, 3'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tbl[3+k] = mk(one << k, 8'h80 >> k, 4'd1, 1'b1, 3'(k), 3'(k), 1'b0);
        end
        tbl[11] = mk(8'h01, 8'h80, 4'd1, 1'b1, 3'd0, 3'd0, 1'b0);
        tbl[12] = mk(8'h80, 8'h01, 4'd1, 1'b1, 3'd7, 3'd7, 1'b0);
        tbl[13] = mk(8'hA5, 8'hA5, 4'd4, 1'b0, 3'd0, 3'd7, 1'b0);
        tbl[14] = mk(8'h3C, 8'h3C, 4'd4, 1'b0, 3'd2, 3'd5, 1'b0);
        tbl[15] = mk(8'h07, 8'hE0, 4'd3, 1'b1, 3'd0, 3'd2, 1'b0);

        // Reset held with all-ones input: edges must be ignored.
        bus.indata_a = 8'hFF;
        sys_rst      = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_hold", '0);

        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Back-to-back stream, first word is the one present at release.
        for (int i = 0; i < 16; i++) step($sformatf("vec%0d", i), tbl[i]);
        flush();

        // Get outputs nonzero, then hit reset between edges.
        step("pre_rst", tbl[13]);
        flush();
        #2;
        sys_rst = 1'b1;
        #1;
        check("async_rst", '0);
        bus.indata_a = 8'hFF;
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_held", '0);

        @(negedge sys_clk);
        sys_rst      = 1'b0;
        bus.indata_a = tbl[14].a;
        exp_q.push_back(tbl[14].exp);
        name_q.push_back("post_release");
        #1;
        check("before_edge", '0);
        @(posedge sys_clk);
        #1;
        if (exp_q.size() >= LAT) check(name_q.pop_front(), exp_q.pop_front());
        flush();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
